// File: rtl/in_xif.sv
// XIF payload types shared between the FPU and the core-side result path.
`ifndef X_ID_WIDTH
`define X_ID_WIDTH 4
`endif
`ifndef XLEN
`define XLEN 32
`endif

package in_xif;

  // Result returned to the core for one offloaded instruction.
  typedef struct packed {
    logic [`X_ID_WIDTH-1:0] id;
    logic [`XLEN-1:0]       data;
    logic [4:0]             rd;
    logic                   we;
  } x_result_t;

  // Commit strobe payload; commit_kill cancels the instruction with this id.
  typedef struct packed {
    logic [`X_ID_WIDTH-1:0] id;
    logic                   commit_kill;
  } x_commit_t;

endpackage : in_xif

// File: rtl/pa_rvfpm.sv
// Shared FPU-side types and defaults for the result buffer.
package pa_rvfpm;

  import in_xif::*;

  // Default number of buffered results.
  localparam int unsigned RB_DEPTH = 4;

  // One buffer slot: the stored result plus its cancellation flag.
  typedef struct packed {
    x_result_t res;
    logic      killed;
  } rb_entry_t;

endpackage : pa_rvfpm

// File: rtl/rvfpm_result_buffer.sv
// In-order result FIFO between the FPU result output and the XIF result
// interface. Entries cancelled by a commit kill are dropped at the head
// without ever being offered to the core.
`ifndef X_ID_WIDTH
`define X_ID_WIDTH 4
`endif
`ifndef XLEN
`define XLEN 32
`endif

module rvfpm_result_buffer
  import in_xif::*;
  import pa_rvfpm::*;
#(
  parameter int unsigned DEPTH      = RB_DEPTH,   // power of two, >= 2
  parameter int unsigned X_ID_WIDTH = `X_ID_WIDTH,
  parameter int unsigned XLEN       = `XLEN
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  x_result_t              in_result,
  input  logic                   commit_valid,
  input  x_commit_t              commit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output x_result_t              out_result,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  rb_entry_t        mem_q [DEPTH];
  rb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push;
  logic             pop;
  logic             drop;
  logic             head_adv;
  logic             non_empty;
  logic             kill_req;
  logic [X_ID_WIDTH-1:0] kill_id;
  rb_entry_t        head_entry;

  // A slot is live when it lies within count entries of the head.
  function automatic logic slot_live(input logic [PTR_W-1:0] idx,
                                     input logic [PTR_W-1:0] head,
                                     input logic [CNT_W-1:0] cnt);
    logic [PTR_W-1:0] off;
    off = idx - head;
    return {1'b0, off} < cnt;
  endfunction

  // Handshake decode; in_ready depends on registered count only.
  always_comb begin
    head_entry = mem_q[head_q];
    non_empty  = (count_q != '0);
    in_ready   = (count_q < CNT_W'(DEPTH));
    out_valid  = non_empty && !head_entry.killed;
    push       = in_valid && in_ready;
    pop        = out_valid && out_ready;
    drop       = non_empty && head_entry.killed;
    head_adv   = pop || drop;
    kill_req   = commit_valid && commit.commit_kill;
    kill_id    = commit.id[X_ID_WIDTH-1:0];
  end

  // Output payload is zeroed whenever nothing is being offered.
  always_comb begin
    out_result = head_entry.res;
    if (!out_valid) begin
      out_result.id   = '0;
      out_result.data = {XLEN{1'b0}};
      out_result.rd   = '0;
      out_result.we   = 1'b0;
    end
  end

  // Next-state for pointers and occupancy.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (head_adv) begin
      head_d = head_q + PTR_W'(1);
    end
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    case ({push, head_adv})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Next-state for storage: apply kills to live entries, then write the push.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      // The head currently offered to the core is never withdrawn: its
      // valid/payload must stay stable until the handshake, and a kill
      // racing the pop loses to the pop.
      if (kill_req
          && slot_live(PTR_W'(i), head_q, count_q)
          && !(out_valid && (PTR_W'(i) == head_q))
          && (mem_q[i].res.id == kill_id)) begin
        mem_d[i].killed = 1'b1;
      end
    end
    if (push) begin
      mem_d[tail_q].res    = in_result;
      mem_d[tail_q].killed = kill_req && (in_result.id == kill_id);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      // NOTE: the payload array is reset too, so a result stored before
      // reset can never resurface and out_result is deterministic.
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign count = count_q;

endmodule : rvfpm_result_buffer

// File: tb/tb_rvfpm_result_buffer.sv
// Directed self-checking bench for rvfpm_result_buffer.
module tb_rvfpm_result_buffer;

  import in_xif::*;

  logic       ck;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  x_result_t  in_result;
  logic       commit_valid;
  x_commit_t  commit;
  logic       out_valid;
  logic       out_ready;
  x_result_t  out_result;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  rvfpm_result_buffer dut (
    .ck           (ck),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .commit_valid (commit_valid),
    .commit       (commit),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .count        (count)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic x_result_t mk(input logic [3:0] id, input logic [31:0] data,
                                   input logic [4:0] rd);
    x_result_t r;
    r.id   = id;
    r.data = data;
    r.rd   = rd;
    r.we   = 1'b1;
    return r;
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic kill(input logic [3:0] id);
    commit_valid       = 1'b1;
    commit.id          = id;
    commit.commit_kill = 1'b1;
  endtask

  x_result_t r;
  logic [3:0] exp_ids [3];

  initial begin
    rst          = 1'b0;
    in_valid     = 1'b0;
    in_result    = '0;
    commit_valid = 1'b0;
    commit       = '0;
    out_ready    = 1'b0;

    // Reset values
    #2;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge ck);
    @(posedge ck);
    #3 rst = 1'b1;
    tick();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single push, pass-through with out_ready high
    r = mk(4'd1, 32'h3F80_0000, 5'd5);
    in_result = r;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("no_bypass", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    check("s1_valid", 64'(out_valid), 64'd1);
    check("s1_payload", 64'(out_result), 64'(r));
    check("s1_count1", 64'(count), 64'd1);
    tick();
    check("s1_count0", 64'(count), 64'd0);
    check("s1_idle_valid", 64'(out_valid), 64'd0);
    check("s1_idle_zero", 64'(out_result), 64'd0);

    // Fill to DEPTH with the core stalled
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_result = mk(4'(8 + k), 32'h1000 + 32'(k), 5'(k));
      in_valid  = 1'b1;
      tick();
    end
    in_result = mk(4'd12, 32'h2000, 5'd12);
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_head", 64'(out_result.id), 64'd8);
    tick();
    check("fifth_ignored", 64'(count), 64'd4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop_in_ready", 64'(in_ready), 64'd1);
    check("pop_count", 64'(count), 64'd3);
    check("pop_head", 64'(out_result.id), 64'd9);

    // Full with push+pop: push refused; then push+pop at DEPTH-1 holds count
    in_result = mk(4'd12, 32'h2000, 5'd12);
    in_valid  = 1'b1;
    tick();
    check("refill_count", 64'(count), 64'd4);
    in_result = mk(4'd13, 32'h3000, 5'd13);
    out_ready = 1'b1;
    #1;
    check("full_pp_ready", 64'(in_ready), 64'd0);
    tick();
    check("full_pp_count", 64'(count), 64'd3);
    check("full_pp_head", 64'(out_result.id), 64'd10);
    in_result = mk(4'd14, 32'h4000, 5'd14);
    tick();
    check("three_pp_count", 64'(count), 64'd3);
    check("three_pp_head", 64'(out_result.id), 64'd11);
    in_valid   = 1'b0;
    exp_ids[0] = 4'd11;
    exp_ids[1] = 4'd12;
    exp_ids[2] = 4'd14;
    for (int k = 0; k < 3; k++) begin
      check("drain_valid", 64'(out_valid), 64'd1);
      check("drain_id", 64'(out_result.id), 64'(exp_ids[k]));
      tick();
    end
    check("drain_count", 64'(count), 64'd0);
    check("drain_idle", 64'(out_valid), 64'd0);

    // Kill a middle entry: ids 2,3,4, kill 3
    out_ready = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      in_result = mk(4'(k), 32'h100 * 32'(k), 5'(k));
      in_valid  = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    kill(4'd3);
    tick();
    commit_valid = 1'b0;
    out_ready    = 1'b1;
    check("k_first_valid", 64'(out_valid), 64'd1);
    check("k_first_id", 64'(out_result.id), 64'd2);
    tick();
    check("k_skip_valid", 64'(out_valid), 64'd0);
    check("k_skip_count", 64'(count), 64'd2);
    tick();
    check("k_second_valid", 64'(out_valid), 64'd1);
    check("k_second_id", 64'(out_result.id), 64'd4);
    tick();
    check("k_count0", 64'(count), 64'd0);

    // Kill in the same cycle as the push of that id
    in_result = mk(4'd7, 32'h7777, 5'd7);
    in_valid  = 1'b1;
    kill(4'd7);
    tick();
    in_valid     = 1'b0;
    commit_valid = 1'b0;
    check("push_kill_valid", 64'(out_valid), 64'd0);
    check("push_kill_count", 64'(count), 64'd1);
    tick();
    check("push_kill_gone", 64'(count), 64'd0);

    // Commit without kill does not affect the entry
    r = mk(4'd5, 32'h5555, 5'd5);
    in_result          = r;
    in_valid           = 1'b1;
    commit_valid       = 1'b1;
    commit.id          = 4'd5;
    commit.commit_kill = 1'b0;
    tick();
    in_valid     = 1'b0;
    commit_valid = 1'b0;
    check("nokill_valid", 64'(out_valid), 64'd1);
    check("nokill_payload", 64'(out_result), 64'(r));
    tick();
    check("nokill_count", 64'(count), 64'd0);

    // Stalled head, then kill races the pop: delivered exactly once
    out_ready = 1'b0;
    r = mk(4'd6, 32'h6666, 5'd6);
    in_result = r;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    check("stall_valid", 64'(out_valid), 64'd1);
    tick();
    check("stall_hold_valid", 64'(out_valid), 64'd1);
    check("stall_hold_payload", 64'(out_result), 64'(r));
    kill(4'd6);
    out_ready = 1'b1;
    #1;
    check("race_valid", 64'(out_valid), 64'd1);
    check("race_payload", 64'(out_result), 64'(r));
    tick();
    commit_valid = 1'b0;
    check("race_count", 64'(count), 64'd0);
    check("race_after_valid", 64'(out_valid), 64'd0);
    tick();
    check("race_once", 64'(out_valid), 64'd0);

    // Reset mid-operation with two entries queued
    out_ready = 1'b0;
    in_result = mk(4'd1, 32'hAAAA, 5'd1);
    in_valid  = 1'b1;
    tick();
    in_result = mk(4'd2, 32'hBBBB, 5'd2);
    tick();
    in_valid = 1'b0;
    check("mid_count", 64'(count), 64'd2);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_result", 64'(out_result), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    tick();
    #2;
    rst = 1'b1;
    tick();
    out_ready = 1'b1;
    check("post_mid_valid", 64'(out_valid), 64'd0);
    check("post_mid_count", 64'(count), 64'd0);
    tick();
    check("post_mid_stale", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rvfpm_result_buffer

// File: doc/rvfpm_result_buffer.md
RVFPM_RESULT_BUFFER -- requirements
Module: rvfpm_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of result entries; a power of two and >= 2.
REQ-002 SHALL have parameter X_ID_WIDTH, default `X_ID_WIDTH, instruction id width.
REQ-003 SHALL have parameter XLEN, default `XLEN, result data width.
REQ-004 SHALL have port ck  input  1  single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  FPU result valid.
REQ-007 SHALL have port in_ready  output  1  buffer can accept a result.
REQ-008 SHALL have port in_result  input  x_result_t  FPU result payload.
REQ-009 SHALL have port commit_valid  input  1  XIF commit strobe.
REQ-010 SHALL have port commit  input  x_commit_t  commit id and commit_kill.
REQ-011 SHALL have port out_valid  output  1  result offered to core.
REQ-012 SHALL have port out_ready  input  1  core accepts result.
REQ-013 SHALL have port out_result  output  x_result_t  head result to core.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries, killed ones included.

Function
REQ-015 SHALL be an in-order FIFO between FPU result output and XIF result interface.
REQ-016 SHALL drive in_ready = (count < DEPTH), from registered state only; no combinational path from out_ready.
REQ-017 SHALL push in_result at the tail when in_valid && in_ready; pointers wrap modulo DEPTH.
REQ-018 SHALL make a pushed entry visible at the head no earlier than the next cycle (no same-cycle bypass).
REQ-019 SHALL drive out_valid = 1 only when the buffer is non-empty and the head entry is not killed.
REQ-020 SHALL pop the head when out_valid && out_ready.
REQ-021 SHALL hold out_result and out_valid stable while out_valid && !out_ready, except on reset.
REQ-022 SHALL, on commit_valid && commit.commit_kill, mark every live entry whose id equals commit.id[X_ID_WIDTH-1:0] as killed.
REQ-023 SHALL also mark killed an entry pushed in the same cycle with a matching id.
REQ-024 SHALL drop a killed head in one cycle with out_valid = 0 and no handshake.
REQ-025 SHALL let the pop win when a kill targets the head being popped in the same cycle.
REQ-026 SHALL ignore commit_valid with commit_kill = 0; non-killed entries need no commit to drain.
REQ-027 SHALL, on simultaneous push and pop or drop, leave count unchanged, including when count = DEPTH-1.
REQ-028 SHALL not push when full, even if a pop occurs that cycle.
REQ-029 SHALL force out_result to all-zero when out_valid = 0.

Reset
REQ-030 SHALL, on rst low, asynchronously clear the pointers, count, all killed flags and stored payloads.
REQ-031 SHALL hold out_valid = 0, out_result = 0 and count = 0 during reset, and in_ready = 1 during and after reset.
REQ-032 SHALL discard entries present at reset mid-operation; nothing is presented after reset release.

Structure
REQ-033 SHALL take the typedef rb_entry_t {x_result_t res; logic killed;} from package pa_rvfpm.
REQ-034 SHALL take the default constant RB_DEPTH = 4 from package pa_rvfpm.
REQ-035 SHALL import x_result_t and x_commit_t from in_xif.
REQ-036 SHALL be a single module with no sub-modules.

Verification
REQ-037 Bench SHALL cover: push id=1 data=0x3F800000 rd=5, out_ready=1 -> out_valid in the next cycle with identical payload, count 1 then 0.
REQ-038 Bench SHALL cover: push 4 results with out_ready=0 -> in_ready=0, count=4, 5th in_valid ignored; one pop -> in_ready=1 the next cycle.
REQ-039 Bench SHALL cover: push ids 2,3,4, then kill id=3 -> core receives only ids 2 and 4; the id 3 slot is skipped with no out_valid cycle.
REQ-040 Bench SHALL cover: full buffer with simultaneous push and pop -> push refused, count 3; at count=3, push+pop -> count stays 3.
REQ-041 Bench SHALL cover: head id=6 stalled, then kill id=6 with out_ready=1 in the same cycle -> handshake completes and the entry is delivered once.
REQ-042 Bench SHALL cover: rst low with 2 entries queued -> count=0, out_valid=0 immediately; after release, no stale results appear.
